// File: rtl/aux_irq_conditioner_pkg.sv
// Shared constants and helpers for the push-button interrupt conditioner.
// Default channel count, default debounce length, and a ms-to-count helper.
package aux_irq_conditioner_pkg;

    localparam int IRQ_CHANNELS     = 3;
    localparam int IRQ_DEBOUNCE_CNT = 16;
    localparam int IRQ_CNT_BIT      = 16;

    // Converts a debounce time in milliseconds to clk cycles for a given core clock.
    function automatic int unsigned cnt_from_ms(input int unsigned clk_hz, input int unsigned ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/aux_debouncer.sv
// One interrupt line: a 2-flop synchroniser, a stability counter and the debounced level.
// Emits a single-cycle rise pulse in the cycle the debounced level toggles from 0 to 1.
module aux_debouncer #(
    parameter int DebounceCnt = 16,
    parameter int CntBit      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);

    localparam logic [CntBit-1:0] CntLast = CntBit'(DebounceCnt - 1);

    logic              s1;
    logic              s2;
    logic              stable;
    logic [CntBit-1:0] cnt;
    logic              toggle;

    assign toggle = (s2 != stable) && (cnt == CntLast);
    assign rise   = toggle && s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (toggle) begin
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CntBit'(1);
            end
        end
    end

endmodule

// File: rtl/aux_irq_conditioner.sv
// Debounces push-button lines into pending requests held until acknowledged, with overrun flags.
// Define IRQ_ONEHOT_EN to present only the lowest-indexed pending request on irq_type.
module aux_irq_conditioner
    import aux_irq_conditioner_pkg::*;
#(
    parameter int Channels    = IRQ_CHANNELS,
    parameter int DebounceCnt = IRQ_DEBOUNCE_CNT,
    parameter int CntBit      = IRQ_CNT_BIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [Channels-1:0] irq_raw,
    input  logic [Channels-1:0] irq_ack,
    input  logic                ovr_clr,
    output logic [Channels-1:0] irq_type,
    output logic [Channels-1:0] irq_pending,
    output logic [Channels-1:0] irq_ovr,
    output logic                irq_any
);

    logic [Channels-1:0] rise;

    for (genvar i = 0; i < Channels; i++) begin : g_ch
        aux_debouncer #(
            .DebounceCnt (DebounceCnt),
            .CntBit      (CntBit)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .raw  (irq_raw[i]),
            .rise (rise[i])
        );
    end

    // A rise beats a simultaneous ack; only a rise onto an unacked pending bit is an overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_pending <= '0;
            irq_ovr     <= '0;
        end else begin
            irq_pending <= rise | (irq_pending & ~irq_ack);
            irq_ovr     <= (rise & irq_pending & ~irq_ack) | (ovr_clr ? '0 : irq_ovr);
        end
    end

    assign irq_any = |irq_pending;

`ifdef IRQ_ONEHOT_EN
    assign irq_type = irq_pending & (~irq_pending + Channels'(1));
`else
    assign irq_type = irq_pending;
`endif

endmodule
